vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA raster timing generator; replaces the ripple clock divider plus fixed 640x480 display controller.
// - Runs directly on the board clock and derives a pixel clock-enable internally, so no derived clock is used.
// - Drives hSync/vSync to the connector and hCount/vCount/bright to the game/maze controllers.
// - Adds pixel-relative coordinates and line/frame strobes for frame-synchronous game logic.
// PARAMETERS
// CLK_DIV    4    board clocks per pixel (>=1; 4 gives 25 MHz from 100 MHz)
// H_VISIBLE  640  visible pixels per line
// H_FRONT    16   horizontal front porch, pixels
// H_SYNC     96   horizontal sync width, pixels
// H_BACK     48   horizontal back porch, pixels
// V_VISIBLE  480  visible lines per frame
// V_FRONT    10   vertical front porch, lines
// V_SYNC     2    vertical sync width, lines
// V_BACK     33   vertical back porch, lines
// SYNC_POL   0    active level of hSync/vSync (0 = active-low)
// CNT_W      10   counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// ClkPort      in   1      board clock
// Reset        in   1      asynchronous, active-high reset
// pix_en       out  1      one-ClkPort-cycle pixel strobe
// hSync        out  1      horizontal sync, level per SYNC_POL
// vSync        out  1      vertical sync, level per SYNC_POL
// bright       out  1      1 while in visible region
// hCount       out  CNT_W  raster column, 0..H_TOTAL-1
// vCount       out  CNT_W  raster line, 0..V_TOTAL-1
// xPix         out  CNT_W  visible column, 0..H_VISIBLE-1; 0 when !bright
// yPix         out  CNT_W  visible line, 0..V_VISIBLE-1; 0 when !bright
// line_start   out  1      pulse when hCount wraps to 0
// frame_start  out  1      pulse when hCount and vCount both wrap to 0
// BEHAVIOUR
// - Derived totals: H_TOTAL = H_SYNC+H_BACK+H_VISIBLE+H_FRONT; V_TOTAL = same sum over V_*.
// - Region order per line/frame: sync, back porch, visible, front porch.
// - H_OFS = H_SYNC+H_BACK; V_OFS = V_SYNC+V_BACK (defaults 144 and 35).
// - Divider: div counts 0..CLK_DIV-1 then wraps.
//   - pix_en is registered, high for the one cycle following div==CLK_DIV-1.
//   - CLK_DIV==1: pix_en is constantly 1 after reset release.
// - Counter advance, on each ClkPort edge with pix_en=1:
//   - hCount increments.
//   - At hCount==H_TOTAL-1: hCount goes to 0 and vCount increments.
//   - At vCount==V_TOTAL-1 (with hCount wrap): vCount goes to 0.
//   - Counters hold while pix_en=0.
// - All outputs are registered and mutually consistent on every cycle. Decodes are computed from next-count values.
//   - hSync active iff hCount < H_SYNC.
//   - vSync active iff vCount < V_SYNC.
//   - bright iff H_OFS <= hCount < H_OFS+H_VISIBLE and V_OFS <= vCount < V_OFS+V_VISIBLE.
//   - xPix = hCount-H_OFS and yPix = vCount-V_OFS when bright, else 0.
// - Strobes:
//   - line_start is 1 for exactly the ClkPort cycle in which hCount==0 is first presented.
//   - frame_start is the same, for hCount==0 && vCount==0.
//   - Both are 0 in every other cycle, including pix_en=0 cycles while hCount stays at 0.
// - Reset (async assert, sync use on release):
//   - div=0, pix_en=0, hCount=vCount=xPix=yPix=0, bright=0, line_start=frame_start=0.
//   - hSync=vSync=SYNC_POL, i.e. active, consistent with count 0 being inside sync.
// - Reset mid-frame: outputs take reset values immediately, independent of ClkPort.
//   - First pix_en arrives CLK_DIV cycles after release.
//   - The raster restarts at (0,0) with no frame_start for that restart.
// - Arithmetic is unsigned CNT_W bit; counters never exceed TOTAL-1.
// TESTING
// - Defaults, reset released: pix_en period = 4 ClkPort cycles; first pix_en exactly 4 cycles after release.
// - Defaults, one line: hSync active for hCount 0..95; bright rises at hCount=144 (xPix=0), falls after hCount=783 (xPix=639).
// - Defaults, frame: vSync active for lines 0..1; visible lines 35..514 (yPix 0..479).
//   - frame_start period = 800*525*4 = 1,680,000 ClkPort cycles.
// - Wrap: at hCount=799,vCount=524 the next pix_en gives (0,0) with line_start=frame_start=1 for exactly one cycle.
// - Reset at hCount=400,vCount=200: all outputs return to reset values asynchronously.
//   - After release the raster restarts at (0,0) with no frame_start pulse.
// - CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, SYNC_POL=1: pix_en stuck at 1; H_TOTAL=14; hSync high for hCount 0..1; bright for hCount 4..11 on lines 2..5.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the sync connector and game logic.
interface vga_timing_gen_if #(
    parameter int unsigned CNT_W = 10
);
    logic             pix_en;
    logic             hSync;
    logic             vSync;
    logic             bright;
    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic [CNT_W-1:0] xPix;
    logic [CNT_W-1:0] yPix;
    logic             line_start;
    logic             frame_start;

    modport master (
        output pix_en, hSync, vSync, bright, hCount, vCount, xPix, yPix, line_start, frame_start
    );

    modport slave (
        input pix_en, hSync, vSync, bright, hCount, vCount, xPix, yPix, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator running on the board clock with an internal pixel enable.
// Every output is registered from the next-count decode so all fields agree on each cycle.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned SYNC_POL  = 0,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             ClkPort,
    input  logic             Reset,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
    localparam int unsigned H_OFS   = H_SYNC + H_BACK;
    localparam int unsigned V_OFS   = V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS_LO = CNT_W'(H_OFS);
    localparam logic [CNT_W-1:0] H_VIS_HI = CNT_W'(H_OFS + H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_LO = CNT_W'(V_OFS);
    localparam logic [CNT_W-1:0] V_VIS_HI = CNT_W'(V_OFS + V_VISIBLE);
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_q;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    logic             hsync_q, vsync_q, bright_q, bright_d;
    logic             line_q, line_d, frame_q, frame_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

        h_d = h_q;
        v_d = v_q;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        bright_d = (h_d >= H_VIS_LO) && (h_d < H_VIS_HI) && (v_d >= V_VIS_LO) && (v_d < V_VIS_HI);
        x_d      = bright_d ? h_d - H_VIS_LO : '0;
        y_d      = bright_d ? v_d - V_VIS_LO : '0;

        // Only a real advance onto column 0 strobes; holding at 0 between enables does not.
        line_d  = pix_en_q && (h_d == '0);
        frame_d = line_d && (v_d == '0);
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            div_q    <= '0;
            pix_en_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            hsync_q  <= SYNC_ACT;
            vsync_q  <= SYNC_ACT;
            bright_q <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= (div_q == DIV_LAST);
            h_q      <= h_d;
            v_q      <= v_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hsync_q  <= (h_d < H_SYNC_C) ? SYNC_ACT : ~SYNC_ACT;
            vsync_q  <= (v_d < V_SYNC_C) ? SYNC_ACT : ~SYNC_ACT;
            bright_q <= bright_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.hSync       = hsync_q;
    assign vga.vSync       = vsync_q;
    assign vga.bright      = bright_q;
    assign vga.hCount      = h_q;
    assign vga.vCount      = v_q;
    assign vga.xPix        = x_q;
    assign vga.yPix        = y_q;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;
endmodule
